// File: rtl/systolic_ctrl.sv
// Sequencer for a 2x2 systolic array: loads weights, switches, streams skewed
// activations, counts results and signals done or timeout.
//
// Ports:
//   clk, rst                       clock, async active-low reset
//   cmd_valid/ready, cmd_rows/cols job command (rows = N vectors, cols 1..2)
//   w_valid/ready, w_data          weight beats {col2, col1}
//   x_valid/ready, x_data          activation beats {row2, row1}
//   sys_*, ub_*                    registered array drive outputs
//   sys_valid_out_x1/x2            array result strobes
//   busy, done, err_timeout        job status
module systolic_ctrl #(
    parameter int DATA_W = 16,
    parameter int ROW_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ROW_W-1:0]    cmd_rows,
    input  logic [1:0]          cmd_cols,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [2*DATA_W-1:0] w_data,
    input  logic                x_valid,
    output logic                x_ready,
    input  logic [2*DATA_W-1:0] x_data,
    output logic [DATA_W-1:0]   sys_data_in_1x,
    output logic [DATA_W-1:0]   sys_data_in_2x,
    output logic                sys_start,
    output logic [DATA_W-1:0]   sys_weight_in_x1,
    output logic [DATA_W-1:0]   sys_weight_in_x2,
    output logic                sys_accept_w_1,
    output logic                sys_accept_w_2,
    output logic                sys_switch_in,
    output logic [15:0]         ub_rd_col_size_in,
    output logic                ub_rd_col_size_valid_in,
    input  logic                sys_valid_out_x1,
    input  logic                sys_valid_out_x2,
    output logic                busy,
    output logic                done,
    output logic                err_timeout
);

    typedef enum logic [2:0] {
        IDLE, CFG, LOAD_W, SWITCH, STREAM, DRAIN, DONE
    } state_t;

    state_t state, next;

    logic             alive;
    logic [ROW_W-1:0] rows, issued, cnt1, cnt2;
    logic             cols2;
    logic             wbeat;
    logic [3:0]       idle;
    logic [DATA_W-1:0] hi_q;

    logic cmd_fire, w_fire, x_fire, last_x;
    logic any_valid, all_in, timeout;

    // alive keeps cmd_ready low until the first edge after reset release
    assign cmd_ready = alive && (state == IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign w_ready   = (state == LOAD_W);
    assign w_fire    = w_valid && w_ready;
    assign x_ready   = (state == STREAM) && (issued < rows);
    assign x_fire    = x_valid && x_ready;
    assign last_x    = x_fire && (issued + ROW_W'(1) == rows);
    assign any_valid = sys_valid_out_x1 || sys_valid_out_x2;
    assign all_in    = (cnt1 == rows) && (!cols2 || cnt2 == rows);
    assign timeout   = !any_valid && (idle == 4'd15);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_comb begin
        next = state;
        unique case (state)
            IDLE:   if (cmd_fire) next = (cmd_rows == '0) ? DONE : CFG;
            CFG:    next = LOAD_W;
            LOAD_W: if (w_fire && wbeat) next = SWITCH;
            SWITCH: next = STREAM;
            STREAM: if (last_x) next = DRAIN;
            DRAIN:  if (all_in || timeout) next = DONE;
            DONE:   next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                   <= IDLE;
            alive                   <= 1'b0;
            rows                    <= '0;
            issued                  <= '0;
            cnt1                    <= '0;
            cnt2                    <= '0;
            cols2                   <= 1'b0;
            wbeat                   <= 1'b0;
            idle                    <= '0;
            hi_q                    <= '0;
            err_timeout             <= 1'b0;
            sys_data_in_1x          <= '0;
            sys_data_in_2x          <= '0;
            sys_start               <= 1'b0;
            sys_weight_in_x1        <= '0;
            sys_weight_in_x2        <= '0;
            sys_accept_w_1          <= 1'b0;
            sys_accept_w_2          <= 1'b0;
            sys_switch_in           <= 1'b0;
            ub_rd_col_size_in       <= '0;
            ub_rd_col_size_valid_in <= 1'b0;
        end else begin
            state <= next;
            alive <= 1'b1;

            if (cmd_fire) begin
                rows        <= cmd_rows;
                cols2       <= (cmd_cols == 2'd2);
                err_timeout <= 1'b0;
                issued      <= '0;
                cnt1        <= '0;
                cnt2        <= '0;
                wbeat       <= 1'b0;
            end

            if (w_fire) wbeat <= 1'b1;
            if (x_fire) issued <= issued + ROW_W'(1);

            // result counters saturate at the job's row count
            if (state == STREAM || state == DRAIN) begin
                if (sys_valid_out_x1 && cnt1 != rows)
                    cnt1 <= cnt1 + ROW_W'(1);
                if (cols2 && sys_valid_out_x2 && cnt2 != rows)
                    cnt2 <= cnt2 + ROW_W'(1);
            end

            idle <= (state == DRAIN && !any_valid) ? idle + 4'd1 : 4'd0;
            if (state == DRAIN && timeout && !all_in) err_timeout <= 1'b1;

            ub_rd_col_size_valid_in <= (state == CFG);
            ub_rd_col_size_in <= (state == CFG) ? (cols2 ? 16'd2 : 16'd1) : 16'd0;

            sys_accept_w_1   <= w_fire;
            sys_accept_w_2   <= w_fire;
            sys_weight_in_x1 <= w_fire ? w_data[DATA_W-1:0] : '0;
            sys_weight_in_x2 <= w_fire ? w_data[2*DATA_W-1:DATA_W] : '0;

            sys_switch_in <= (state == SWITCH);

            // row 2 travels one extra register to form the diagonal skew
            sys_start      <= x_fire;
            sys_data_in_1x <= x_fire ? x_data[DATA_W-1:0] : '0;
            hi_q           <= x_fire ? x_data[2*DATA_W-1:DATA_W] : '0;
            sys_data_in_2x <= hi_q;
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: directed and random jobs against a simple
// array model and an event-log reference derived from the job description.
module tb_systolic_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_rows = '0;
    logic [1:0]  cmd_cols = '0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [31:0] w_data = '0;
    logic        x_valid = 1'b0;
    logic        x_ready;
    logic [31:0] x_data = '0;
    logic [15:0] sys_data_in_1x, sys_data_in_2x;
    logic        sys_start;
    logic [15:0] sys_weight_in_x1, sys_weight_in_x2;
    logic        sys_accept_w_1, sys_accept_w_2, sys_switch_in;
    logic [15:0] ub_rd_col_size_in;
    logic        ub_rd_col_size_valid_in;
    logic        sys_valid_out_x1 = 1'b0;
    logic        sys_valid_out_x2 = 1'b0;
    logic        busy, done, err_timeout;

    systolic_ctrl #(.DATA_W(16), .ROW_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rows(cmd_rows), .cmd_cols(cmd_cols),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .sys_data_in_1x(sys_data_in_1x), .sys_data_in_2x(sys_data_in_2x),
        .sys_start(sys_start),
        .sys_weight_in_x1(sys_weight_in_x1), .sys_weight_in_x2(sys_weight_in_x2),
        .sys_accept_w_1(sys_accept_w_1), .sys_accept_w_2(sys_accept_w_2),
        .sys_switch_in(sys_switch_in),
        .ub_rd_col_size_in(ub_rd_col_size_in),
        .ub_rd_col_size_valid_in(ub_rd_col_size_valid_in),
        .sys_valid_out_x1(sys_valid_out_x1), .sys_valid_out_x2(sys_valid_out_x2),
        .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // array model: results appear a few cycles after each start
    logic [7:0] p = '0;
    bit sup1 = 1'b0, sup2 = 1'b0;
    always @(negedge clk) begin
        p <= {p[6:0], sys_start};
        sys_valid_out_x1 <= p[1] && !sup1;
        sys_valid_out_x2 <= p[2] && !sup2;
    end

    // event logs
    logic [31:0] accq[$];
    int          stc[$];
    logic [15:0] std_q[$];
    int          d2c[$];
    logic [15:0] d2v[$];
    int sw_n = 0, ub_n = 0, done_n = 0, done_c = 0, aw_mis = 0, stray = 0;
    logic [15:0] ub_sz = '0;

    always @(negedge clk) begin
        if (sys_accept_w_1) accq.push_back({sys_weight_in_x2, sys_weight_in_x1});
        if (sys_accept_w_1 != sys_accept_w_2) aw_mis <= aw_mis + 1;
        if (sys_switch_in) sw_n <= sw_n + 1;
        if (sys_start) begin
            stc.push_back(cyc);
            std_q.push_back(sys_data_in_1x);
        end else if (sys_data_in_1x != 0) stray <= stray + 1;
        if (sys_data_in_2x != 0) begin
            d2c.push_back(cyc);
            d2v.push_back(sys_data_in_2x);
        end
        if (ub_rd_col_size_valid_in) begin
            ub_n  <= ub_n + 1;
            ub_sz <= ub_rd_col_size_in;
        end
        if (done) begin
            done_n <= done_n + 1;
            done_c <= cyc;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic job(input int rows, input logic [1:0] cols, input bit s1,
                       input bit s2, input int gap, input bit dir,
                       input bit exp_to, input int stop_at);
        logic [31:0] wv[2];
        logic [31:0] xv[$];
        int ac[$];
        int b_acc, b_st, b_d2, b_sw, b_ub, b_done, hs, t, g, n;
        sup1 = s1;
        sup2 = s2;
        for (int i = 0; i < 2; i++)
            wv[i] = {16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535))};
        for (int i = 0; i < rows; i++)
            xv.push_back({16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535))});
        if (dir) begin
            wv[0] = {16'd6, 16'd5};
            wv[1] = {16'd8, 16'd7};
            xv.delete();
            xv.push_back({16'd2, 16'd1});
            xv.push_back({16'd4, 16'd3});
            xv.push_back({16'd6, 16'd5});
        end
        b_acc = accq.size(); b_st = stc.size(); b_d2 = d2c.size();
        b_sw = sw_n; b_ub = ub_n; b_done = done_n;

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_rows = 8'(rows);
        cmd_cols = cols;
        chk("cmd_ready_idle", cmd_ready, 1);
        hs = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("err_clear_on_cmd", err_timeout, 0);

        if (rows > 0) begin
            for (int b = 0; b < 2; b++) begin
                w_valid = 1'b1;
                w_data = wv[b];
                t = 0;
                while (!w_ready && t < 50) begin @(negedge clk); t++; end
                chk("w_ready_wait", w_ready, 1);
                @(negedge clk);
                w_valid = 1'b0;
            end
            n = (stop_at >= 0) ? stop_at : rows;
            for (int i = 0; i < n; i++) begin
                g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                if (i > 0) repeat (g) @(negedge clk);
                x_valid = 1'b1;
                x_data = xv[i];
                t = 0;
                while (!x_ready && t < 50) begin @(negedge clk); t++; end
                chk("x_ready_wait", x_ready, 1);
                ac.push_back(cyc);
                @(negedge clk);
                x_valid = 1'b0;
            end
            if (stop_at >= 0) return;
        end

        t = 0;
        while (done_n == b_done && t < 200) begin @(negedge clk); #1; t++; end
        repeat (4) @(negedge clk);
        #1;
        chk("done_once", done_n - b_done, 1);
        chk("err_timeout", err_timeout, exp_to);
        chk("busy_after", busy, 0);
        chk("cmd_ready_after", cmd_ready, 1);

        if (rows == 0) begin
            chk("rows0_done_lat", done_c - hs, 1);
            chk("rows0_no_accept", accq.size() - b_acc, 0);
            chk("rows0_no_switch", sw_n - b_sw, 0);
            chk("rows0_no_start", stc.size() - b_st, 0);
        end else begin
            chk("accept_n", accq.size() - b_acc, 2);
            if (accq.size() - b_acc >= 2) begin
                chk("weights_first", accq[b_acc], wv[0]);
                chk("weights_second", accq[b_acc+1], wv[1]);
            end
            chk("switch_n", sw_n - b_sw, 1);
            chk("ub_valid_n", ub_n - b_ub, 1);
            chk("ub_size", ub_sz, (cols == 2'd2) ? 2 : 1);
            chk("start_n", stc.size() - b_st, rows);
            chk("d2_n", d2c.size() - b_d2, rows);
            if (stc.size() - b_st == rows && d2c.size() - b_d2 == rows) begin
                for (int i = 0; i < rows; i++) begin
                    chk("start_cycle", stc[b_st+i], ac[i] + 1);
                    chk("data_1x", std_q[b_st+i], xv[i][15:0]);
                    chk("d2_cycle", d2c[b_d2+i], stc[b_st+i] + 1);
                    chk("data_2x", d2v[b_d2+i], xv[i][31:16]);
                end
                if (exp_to)
                    chk("timeout_lat", done_c - stc[b_st+rows-1], 16);
            end
        end
        chk("accept_w_pair", aw_mis, 0);
        chk("stray_data_1x", stray, 0);
    endtask

    initial begin
        int bd;
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_x_ready", x_ready, 0);
        chk("rst_start", sys_start, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("cmd_ready_before_edge", cmd_ready, 0);
        @(negedge clk);
        chk("cmd_ready_first_edge", cmd_ready, 1);

        job(3, 2'd2, 0, 0, 0, 1, 0, -1);
        job(3, 2'd2, 0, 0, 2, 1, 0, -1);
        job(0, 2'd2, 0, 0, 0, 0, 0, -1);
        job(2, 2'd1, 0, 1, 0, 0, 0, -1);
        job(2, 2'd2, 1, 1, 0, 0, 1, -1);
        for (int k = 0; k < 6; k++)
            job(int'($urandom_range(1, 6)), 2'($urandom_range(0, 2)),
                0, 0, -1, 0, 0, -1);

        job(4, 2'd2, 0, 0, 0, 0, 0, 1);
        bd = done_n;
        #2 rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_ready", cmd_ready, 0);
        chk("midrst_x_ready", x_ready, 0);
        chk("midrst_start", sys_start, 0);
        chk("midrst_data_1x", sys_data_in_1x, 0);
        chk("midrst_data_2x", sys_data_in_2x, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("release_cmd_ready_low", cmd_ready, 0);
        @(negedge clk);
        #1;
        chk("release_cmd_ready", cmd_ready, 1);
        repeat (20) @(negedge clk);
        #1;
        chk("midrst_no_done", done_n - bd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
